// File: rtl/pool_row_buffer_pkg.sv
// Shared types and defaults for the pool row buffer slice.
package pool_pkg;

  localparam int DEF_BITS = 8;
  localparam int DEF_DIM  = 32;

  typedef enum logic [1:0] {
    EMPTY   = 2'd0,
    FILLING = 2'd1,
    FULL    = 2'd2
  } bank_state_e;

  typedef logic signed [2*DEF_BITS-1:0] word_t;

endpackage

// File: rtl/pool_row_buffer_if.sv
// Producer row stream and consumer matrix handshake of the row buffer.
interface pool_row_buffer_if #(
  parameter int BITS = pool_pkg::DEF_BITS,
  parameter int DIM  = pool_pkg::DEF_DIM
);
  logic                                   in_valid;
  logic                                   in_ready;
  logic [DIM-1:0][2*BITS-1:0]             in_row;
  logic                                   in_flush;
  logic                                   relu_en;
  logic                                   out_valid;
  logic                                   out_ready;
  logic [DIM-1:0][DIM-1:0][2*BITS-1:0]    out_matrix;
  logic [$clog2(DIM):0]                   fill_rows;

  // Buffer side.
  modport slave (
    input  in_valid, in_row, in_flush, relu_en, out_ready,
    output in_ready, out_valid, out_matrix, fill_rows
  );

  // Producer/consumer side.
  modport master (
    output in_valid, in_row, in_flush, relu_en, out_ready,
    input  in_ready, out_valid, out_matrix, fill_rows
  );
endinterface

// File: rtl/pool_row_buffer_bank.sv
// One DIM x DIM bank: row write port with optional ReLU, async clear, full read.
module pool_bank
  import pool_pkg::*;
#(
  parameter int BITS = DEF_BITS,
  parameter int DIM  = DEF_DIM
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic                                we,
  input  logic [$clog2(DIM)-1:0]              rowIdx,
  input  logic [DIM-1:0][2*BITS-1:0]          rowData,
  input  logic                                reluEn,
  output logic [DIM-1:0][DIM-1:0][2*BITS-1:0] matrix
);

  logic [DIM-1:0][2*BITS-1:0] rowClamped;

  // Zero any negative word when ReLU is requested for this row.
  always_comb begin
    rowClamped = rowData;
    if (reluEn) begin
      for (int unsigned c = 0; c < DIM; c++) begin
        if (rowData[c][2*BITS-1]) rowClamped[c] = '0;
      end
    end
  end

  // Row storage, cleared on reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      matrix <= '0;
    end else if (we) begin
      matrix[rowIdx] <= rowClamped;
    end
  end

endmodule

// File: rtl/pool_row_buffer.sv
// Ping-pong row collector feeding the 2x2 max-pool stage.
module pool_row_buffer
  import pool_pkg::*;
#(
  parameter int BITS = DEF_BITS,
  parameter int DIM  = DEF_DIM
) (
  input  logic              clk,
  input  logic              rst_n,
  pool_row_buffer_if.slave  bus
);

  localparam int CW = $clog2(DIM) + 1;

  bank_state_e                         bankState [2];
  logic                                wrBank;
  logic                                rdBank;
  logic [CW-1:0]                       rowCnt;
  logic                                accept;
  logic                                release_;
  logic [DIM-1:0][DIM-1:0][2*BITS-1:0] mat0;
  logic [DIM-1:0][DIM-1:0][2*BITS-1:0] mat1;

  // Handshake decode from registered state only.
  always_comb begin
    bus.in_ready   = (bankState[wrBank] != FULL);
    bus.out_valid  = (bankState[rdBank] == FULL);
    bus.out_matrix = rdBank ? mat1 : mat0;
    bus.fill_rows  = rowCnt;
    accept         = bus.in_valid & bus.in_ready & ~bus.in_flush;
    release_       = bus.out_valid & bus.out_ready;
  end

  // Bank state, pointers and row counter. A release always targets a FULL
  // bank while a write/flush targets a non-FULL one, so both updates can
  // coexist in the same cycle without touching the same entry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bankState[0] <= EMPTY;
      bankState[1] <= EMPTY;
      wrBank       <= 1'b0;
      rdBank       <= 1'b0;
      rowCnt       <= '0;
    end else begin
      if (release_) begin
        bankState[rdBank] <= EMPTY;
        rdBank            <= ~rdBank;
      end
      if (bus.in_flush) begin
        if (bankState[wrBank] == FILLING) begin
          bankState[wrBank] <= EMPTY;
          rowCnt            <= '0;
        end
      end else if (accept) begin
        if (rowCnt == CW'(DIM - 1)) begin
          bankState[wrBank] <= FULL;
          rowCnt            <= '0;
          wrBank            <= ~wrBank;
        end else begin
          bankState[wrBank] <= FILLING;
          rowCnt            <= rowCnt + 1'b1;
        end
      end
    end
  end

  pool_bank #(.BITS(BITS), .DIM(DIM)) uBank0 (
    .clk     (clk),
    .rst_n   (rst_n),
    .we      (accept & ~wrBank),
    .rowIdx  (rowCnt[CW-2:0]),
    .rowData (bus.in_row),
    .reluEn  (bus.relu_en),
    .matrix  (mat0)
  );

  pool_bank #(.BITS(BITS), .DIM(DIM)) uBank1 (
    .clk     (clk),
    .rst_n   (rst_n),
    .we      (accept & wrBank),
    .rowIdx  (rowCnt[CW-2:0]),
    .rowData (bus.in_row),
    .reluEn  (bus.relu_en),
    .matrix  (mat1)
  );

endmodule

// File: tb/tb_pool_row_buffer.sv
// Directed bench for pool_row_buffer at DIM=4, BITS=8.
module tb_pool_row_buffer;

  localparam int BITS = 8;
  localparam int DIM  = 4;

  logic clk = 1'b0;
  logic rst_n;
  int   checkCnt = 0;
  int   errCnt   = 0;

  pool_row_buffer_if #(.BITS(BITS), .DIM(DIM)) bus ();

  pool_row_buffer #(.BITS(BITS), .DIM(DIM)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic checkVal(input string tag, input logic [255:0] got, input logic [255:0] exp);
    checkCnt++;
    if (got !== exp) begin
      errCnt++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Word (r,c) of test matrix 'tag' is tag*16 + r*4 + c.
  function automatic logic [63:0] mkRow(input int tag, input int r);
    logic [63:0] row;
    for (int c = 0; c < DIM; c++) row[c*16 +: 16] = 16'(tag*16 + r*4 + c);
    return row;
  endfunction

  function automatic logic [255:0] mkMat(input int tag);
    logic [255:0] m;
    for (int r = 0; r < DIM; r++) m[r*64 +: 64] = mkRow(tag, r);
    return m;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pushRow(input logic [63:0] row, input logic relu);
    bus.in_valid = 1'b1;
    bus.in_row   = row;
    bus.relu_en  = relu;
    tick();
    bus.in_valid = 1'b0;
    bus.relu_en  = 1'b0;
  endtask

  task automatic pulseOut();
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
  endtask

  logic [255:0] expM;
  logic [63:0]  r0;

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_row    = '0;
    bus.in_flush  = 1'b0;
    bus.relu_en   = 1'b0;
    bus.out_ready = 1'b0;
    rst_n         = 1'b0;
    #12;
    checkVal("rst_out_valid", 256'(bus.out_valid), 256'd0);
    checkVal("rst_in_ready", 256'(bus.in_ready), 256'd1);
    checkVal("rst_fill_rows", 256'(bus.fill_rows), 256'd0);
    checkVal("rst_matrix", bus.out_matrix, 256'd0);
    rst_n = 1'b1;
    tick();

    // Basic fill of bank 0.
    for (int r = 0; r < 3; r++) pushRow(mkRow(0, r), 1'b0);
    checkVal("fill3_rows", 256'(bus.fill_rows), 256'd3);
    checkVal("fill3_valid", 256'(bus.out_valid), 256'd0);
    pushRow(mkRow(0, 3), 1'b0);
    checkVal("fill4_valid", 256'(bus.out_valid), 256'd1);
    checkVal("elem_2_3", 256'(bus.out_matrix[2][3]), 256'd11);
    checkVal("fill4_matrix", bus.out_matrix, mkMat(0));
    checkVal("fill4_rows", 256'(bus.fill_rows), 256'd0);
    checkVal("fill4_in_ready", 256'(bus.in_ready), 256'd1);
    pulseOut();
    checkVal("rel0_valid", 256'(bus.out_valid), 256'd0);

    // ReLU on bank 1: row 0 clamped, row 1 negative words kept with relu off.
    r0 = {16'hFFFF, 16'h0005, 16'h8000, 16'h7FFF};
    pushRow(r0, 1'b1);
    pushRow({4{16'hFFF0}}, 1'b0);
    pushRow(mkRow(1, 2), 1'b0);
    pushRow(mkRow(1, 3), 1'b0);
    checkVal("relu_valid", 256'(bus.out_valid), 256'd1);
    checkVal("relu_row0", 256'(bus.out_matrix[0]), 256'({16'h0000, 16'h0005, 16'h0000, 16'h7FFF}));
    checkVal("relu_off_row1", 256'(bus.out_matrix[1]), 256'({4{16'hFFF0}}));
    pulseOut();

    // Fill both banks with the consumer stalled.
    for (int r = 0; r < DIM; r++) pushRow(mkRow(1, r), 1'b0);
    for (int r = 0; r < DIM; r++) pushRow(mkRow(2, r), 1'b0);
    checkVal("both_full_in_ready", 256'(bus.in_ready), 256'd0);
    checkVal("both_full_valid", 256'(bus.out_valid), 256'd1);
    bus.in_valid = 1'b1;
    bus.in_row   = mkRow(3, 0);
    tick();
    tick();
    bus.in_valid = 1'b0;
    checkVal("stall_in_ready", 256'(bus.in_ready), 256'd0);
    checkVal("stall_fill_rows", 256'(bus.fill_rows), 256'd0);
    checkVal("stall_matrix_b0", bus.out_matrix, mkMat(1));
    pulseOut();
    checkVal("swap_valid", 256'(bus.out_valid), 256'd1);
    checkVal("swap_matrix_b1", bus.out_matrix, mkMat(2));
    checkVal("swap_in_ready", 256'(bus.in_ready), 256'd1);
    checkVal("swap_fill_rows", 256'(bus.fill_rows), 256'd0);
    pulseOut();
    checkVal("drain_valid", 256'(bus.out_valid), 256'd0);

    // Completion of bank 1 in the cycle bank 0 is released.
    for (int r = 0; r < DIM; r++) pushRow(mkRow(4, r), 1'b0);
    for (int r = 0; r < DIM - 1; r++) pushRow(mkRow(5, r), 1'b0);
    checkVal("simul_pre_matrix", bus.out_matrix, mkMat(4));
    bus.out_ready = 1'b1;
    pushRow(mkRow(5, 3), 1'b0);
    bus.out_ready = 1'b0;
    checkVal("simul_valid", 256'(bus.out_valid), 256'd1);
    checkVal("simul_matrix", bus.out_matrix, mkMat(5));
    checkVal("simul_in_ready", 256'(bus.in_ready), 256'd1);
    pulseOut();
    checkVal("simul_drain", 256'(bus.out_valid), 256'd0);

    // Flush with a same-cycle row, then refill.
    pushRow(mkRow(6, 0), 1'b0);
    pushRow(mkRow(6, 1), 1'b0);
    checkVal("preflush_rows", 256'(bus.fill_rows), 256'd2);
    bus.in_flush = 1'b1;
    pushRow(mkRow(7, 0), 1'b0);
    bus.in_flush = 1'b0;
    checkVal("flush_rows", 256'(bus.fill_rows), 256'd0);
    checkVal("flush_valid", 256'(bus.out_valid), 256'd0);
    for (int r = 0; r < DIM - 1; r++) pushRow(mkRow(8, r), 1'b0);
    checkVal("refill3_rows", 256'(bus.fill_rows), 256'd3);
    pushRow(mkRow(8, 3), 1'b0);
    checkVal("refill_valid", 256'(bus.out_valid), 256'd1);
    checkVal("refill_matrix", bus.out_matrix, mkMat(8));

    // Async reset with one bank FULL and the other FILLING.
    pushRow(mkRow(9, 0), 1'b0);
    pushRow(mkRow(9, 1), 1'b0);
    checkVal("prerst_rows", 256'(bus.fill_rows), 256'd2);
    #2;
    rst_n = 1'b0;
    #1;
    checkVal("arst_valid", 256'(bus.out_valid), 256'd0);
    checkVal("arst_in_ready", 256'(bus.in_ready), 256'd1);
    checkVal("arst_matrix", bus.out_matrix, 256'd0);
    checkVal("arst_fill_rows", 256'(bus.fill_rows), 256'd0);
    #10;
    rst_n = 1'b1;
    tick();

    // Fresh fill after reset lands in bank 0 again.
    for (int r = 0; r < DIM; r++) pushRow(mkRow(10, r), 1'b0);
    expM = mkMat(10);
    checkVal("post_rst_matrix", bus.out_matrix, expM);

    $display("CHECKS %0d ERRORS %0d", checkCnt, errCnt);
    $finish;
  end

endmodule

// File: doc/pool_row_buffer.md
Name: pool_row_buffer

Overview:
Ping-pong row collector that sits directly upstream of the 2x2 max-pool stage. It accepts convolution-result rows (DIM words of 2*BITS each) one per handshake and optionally applies ReLU on write. Once DIM rows are captured, it presents the complete DIM x DIM matrix to the pooler with a valid/ready handshake. Two banks let the next matrix fill while the previous one is held for the consumer.

Parameters:
BITS, 8, base operand width; stored words are 2*BITS wide (signed two's complement)
DIM, 32, matrix dimension (rows = columns); must be even and >= 2

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  reset; asynchronous, active-low
in_valid  in  1  producer has a row on in_row
in_ready  out  1  buffer can accept a row this cycle
in_row  in  [2*BITS-1:0] x [DIM-1:0]  one matrix row; element j = column j
in_flush  in  1  discard any partially filled bank
relu_en  in  1  clamp negative words to 0 on write
out_valid  out  1  a complete matrix is held on out_matrix
out_ready  in  1  consumer has taken the matrix
out_matrix  out  [2*BITS-1:0] x [DIM-1:0][DIM-1:0]  [row][col], feeds the pooler's dataIn
fill_rows  out  $clog2(DIM)+1  rows written into the current write bank

Behaviour:
- Reset (async, rst_n=0):
  - bank states EMPTY; wr_bank=0; rd_bank=0; row_cnt=0.
  - All storage cleared to 0.
  - Outputs: in_ready=1, out_valid=0, out_matrix all 0, fill_rows=0.
- Bank state per bank (pool_pkg::bank_state_e): EMPTY -> FILLING on the first accepted row; FILLING -> FULL on the accept of row DIM-1; FULL -> EMPTY on the output handshake.
- in_ready = (state[wr_bank] != FULL). It is combinational from registered state only, with no path from in_valid.
- Write accept (in_valid & in_ready):
  - Row stored at bank[wr_bank][row_cnt].
  - row_cnt increments.
  - On row DIM-1: row_cnt -> 0, state[wr_bank] -> FULL, wr_bank toggles.
- ReLU: when relu_en=1, a word with MSB=1 is stored as 0; otherwise it is stored unchanged. relu_en is sampled per row at accept.
- out_valid = (state[rd_bank] == FULL). out_matrix = bank[rd_bank] contents, muxed from registers with no added latency.
- Output handshake (out_valid & out_ready): state[rd_bank] -> EMPTY, rd_bank toggles. out_matrix must stay stable while out_valid=1 and out_ready=0.
- Latency: out_valid rises the cycle after the final row is accepted, if that bank becomes rd_bank. Minimum fill-to-valid is 1 cycle.
- Simultaneous completion of one bank and release of the other in the same cycle:
  - Both transitions happen.
  - out_valid stays 1 next cycle showing the new bank.
  - in_ready stays 1.
- Both banks FULL: in_ready=0. Rows presented are not accepted, and the producer must hold them.
- in_flush:
  - If state[wr_bank]==FILLING: state -> EMPTY, row_cnt -> 0, stale data left in place (it is overwritten on refill).
  - FULL banks are unaffected.
  - in_flush has priority over a same-cycle write accept; that row is dropped.
- fill_rows = row_cnt. It reads 0 while the write bank is FULL.
- Reset asserted mid-fill or mid-hold: everything returns to reset values immediately, and no partial matrix is ever presented.

Decomposition:
- pool_pkg holds:
  - bank_state_e typedef (EMPTY, FILLING, FULL);
  - default BITS/DIM localparams;
  - word_t typedef (logic signed [2*BITS-1:0]).
- Sub-module pool_bank (one per bank, instantiated twice) holds:
  - DIM x DIM storage;
  - row write port (we, row index, row data, relu_en);
  - async clear;
  - full-matrix read port.
- Top level holds the counters, state machine and read mux.

Test Plan:
(Directed tests use DIM=4, BITS=8.)
- Reset then 4 rows of word=row*4+col, relu_en=0 -> out_valid rises the cycle after the 4th accept; out_matrix[2][3]=11; fill_rows back to 0.
- relu_en=1, row 0 = {16'hFFFF, 16'h0005, 16'h8000, 16'h7FFF} -> stored {0, 5, 0, 16'h7FFF}.
- Fill 8 rows with out_ready=0:
  - in_ready=0 after 8 accepts;
  - 9th row not accepted;
  - out_matrix stays on bank 0;
  - pulsing out_ready once shows bank 1, and in_ready returns to 1.
- Bank 1 completes in the same cycle bank 0 is released -> out_valid holds 1 continuously and out_matrix switches to bank 1 data.
- 2 rows written, in_flush=1 with in_valid=1 -> fill_rows=0, flushed-cycle row dropped; a subsequent 4 rows produce a matrix with no stale rows.
- rst_n asserted with one bank FULL and one FILLING -> out_valid=0, in_ready=1, out_matrix=0 asynchronously, before the next clock edge.
